// File: rtl/pkt_arb_pkg.sv
// rtl/pkt_arb_pkg.sv - shared state encoding and parameter defaults for the two-port packet arbiter
package pkt_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2
  } state_e;

  localparam int DW_DEF     = 8;
  localparam int TO_CYC_DEF = 2047;

endpackage

// File: rtl/pkt_arb_rr.sv
// rtl/pkt_arb_rr.sv - two-way round-robin pick; on a tie the port that did not win last time is chosen
module pkt_arb_rr (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic gnt
);

  always_comb begin
    gnt = 1'b0;
    if (req0 && req1) begin
      gnt = ~last_gnt;
    end else if (req1) begin
      gnt = 1'b1;
    end
  end

endmodule

// File: rtl/pkt_arb2.sv
// rtl/pkt_arb2.sv - merges two show-ahead packet FIFOs into one stream, arbitrating only at packet boundaries
// Optional stall timeout with forced eop word is enabled by defining PKT_ARB_TIMEOUT_EN.
module pkt_arb2
  import pkt_arb_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic          din0_vld,
  input  logic          din1_vld,
  input  logic          din0_sop,
  input  logic          din1_sop,
  input  logic          din0_eop,
  input  logic          din1_eop,
  output logic          rd0,
  output logic          rd1,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          dout_sop,
  output logic          dout_eop,
  output logic          dout_src,
  output logic          err
);

  state_e        state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic          wait_sop_q, wait_sop_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dout_vld_q, dout_vld_d;
  logic          dout_sop_q, dout_sop_d;
  logic          dout_eop_q, dout_eop_d;
  logic          dout_src_q, dout_src_d;
  logic          err_q, err_d;

  logic          gnt;
  logic          in_rd;
  logic          cur_src;
  logic          cur_vld;
  logic          cur_sop;
  logic          cur_eop;
  logic [DW-1:0] cur_data;
  logic          xfer;
  logic          to_hit;

  pkt_arb_rr u_rr (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt_q),
    .gnt      (gnt)
  );

  assign in_rd    = (state_q == RD0) || (state_q == RD1);
  assign cur_src  = (state_q == RD1);
  assign cur_vld  = cur_src ? din1_vld : din0_vld;
  assign cur_sop  = cur_src ? din1_sop : din0_sop;
  assign cur_eop  = cur_src ? din1_eop : din0_eop;
  assign cur_data = cur_src ? din1 : din0;
  assign xfer     = in_rd && cur_vld;

  assign rd0 = (state_q == RD0) && din0_vld;
  assign rd1 = (state_q == RD1) && din1_vld;

`ifdef PKT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Counts consecutive stalled read cycles; fires on the TO_CYC-th one.
  always_comb begin
    to_cnt_d = '0;
    to_hit   = 1'b0;
    if (in_rd && !xfer) begin
      if (to_cnt_q == TW'(TO_CYC - 1)) begin
        to_hit = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    wait_sop_d = wait_sop_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    dout_sop_d = 1'b0;
    dout_eop_d = 1'b0;
    dout_src_d = dout_src_q;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d    = gnt ? RD1 : RD0;
          last_gnt_d = gnt;
          wait_sop_d = 1'b1;
        end
      end
      default: begin
        if (!in_rd) begin
          state_d = IDLE;
        end else if (xfer) begin
          // Words popped before the first sop of a grant are discarded.
          if (wait_sop_q && !cur_sop) begin
            err_d = 1'b1;
          end else begin
            dout_d     = cur_data;
            dout_vld_d = 1'b1;
            dout_sop_d = cur_sop;
            dout_eop_d = cur_eop;
            dout_src_d = cur_src;
            wait_sop_d = 1'b0;
            if (cur_eop) begin
              state_d = IDLE;
            end
          end
        end
      end
    endcase

    if (to_hit) begin
      state_d    = IDLE;
      dout_d     = '0;
      dout_vld_d = 1'b1;
      dout_sop_d = 1'b0;
      dout_eop_d = 1'b1;
      dout_src_d = cur_src;
      err_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      wait_sop_q <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      dout_sop_q <= 1'b0;
      dout_eop_q <= 1'b0;
      dout_src_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      wait_sop_q <= wait_sop_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      dout_sop_q <= dout_sop_d;
      dout_eop_q <= dout_eop_d;
      dout_src_q <= dout_src_d;
      err_q      <= err_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign dout_sop = dout_sop_q;
  assign dout_eop = dout_eop_q;
  assign dout_src = dout_src_q;
  assign err      = err_q;

endmodule

// File: tb/tb_pkt_arb2.sv
// tb/tb_pkt_arb2.sv - directed bench for pkt_arb2 with upstream FIFO models and an expected-word queue
module tb_pkt_arb2;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0, req1;
  logic [DW-1:0] din0, din1;
  logic          din0_vld, din1_vld, din0_sop, din1_sop, din0_eop, din1_eop;
  logic          rd0, rd1;
  logic [DW-1:0] dout;
  logic          dout_vld, dout_sop, dout_eop, dout_src, err;

  always #5 clk = ~clk;

  pkt_arb2 #(.DW(DW), .TO_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .din0(din0), .din1(din1),
    .din0_vld(din0_vld), .din1_vld(din1_vld),
    .din0_sop(din0_sop), .din1_sop(din1_sop),
    .din0_eop(din0_eop), .din1_eop(din1_eop),
    .rd0(rd0), .rd1(rd1),
    .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop),
    .dout_eop(dout_eop), .dout_src(dout_src), .err(err)
  );

  // word layout {sop, eop, data}; expected layout {src, sop, eop, data}
  logic [9:0]  q0[$];
  logic [9:0]  q1[$];
  logic [10:0] exp_q[$];
  int eop0, eop1, pops0, pops1;
  int vectors, miscompares, bubbles, errs;
  bit seen_first, lat_chk, stall0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic push_pkt(input int port, input int len, input int start, input bit bad);
    logic [9:0] w;
    if (bad) begin
      w = {1'b0, 1'b0, 8'hEE};
      if (port == 0) q0.push_back(w); else q1.push_back(w);
    end
    for (int i = 0; i < len; i++) begin
      w = {(i == 0), (i == len - 1), 8'((start + i) % 256)};
      if (port == 0) q0.push_back(w); else q1.push_back(w);
      exp_q.push_back({port[0], w});
    end
    if (port == 0) eop0++; else eop1++;
  endtask

  task automatic set_inputs();
    din0     = (q0.size() > 0) ? q0[0][7:0] : '0;
    din0_sop = (q0.size() > 0) ? q0[0][9] : 1'b0;
    din0_eop = (q0.size() > 0) ? q0[0][8] : 1'b0;
    din0_vld = (q0.size() > 0) && !stall0;
    req0     = (eop0 > 0);
    din1     = (q1.size() > 0) ? q1[0][7:0] : '0;
    din1_sop = (q1.size() > 0) ? q1[0][9] : 1'b0;
    din1_eop = (q1.size() > 0) ? q1[0][8] : 1'b0;
    din1_vld = (q1.size() > 0);
    req1     = (eop1 > 0);
  endtask

  task automatic check_out(input bit popped);
    if (dout_vld) begin
      if (exp_q.size() == 0) chk("extra_word", 32'(dout), 32'hFFFF_FFFF);
      else chk("word", 32'({dout_src, dout_sop, dout_eop, dout}), 32'(exp_q.pop_front()));
      seen_first = 1'b1;
    end else if (seen_first && exp_q.size() > 0) begin
      bubbles++;
    end
    if (err) errs++;
    if (lat_chk) chk("latency", 32'(dout_vld), 32'(popped));
  endtask

  // starts and ends at a falling edge
  task automatic cycle();
    logic p0, p1;
    logic [9:0] w;
    set_inputs();
    #1;
    p0 = rd0;
    p1 = rd1;
    @(posedge clk);
    if (p0) begin w = q0.pop_front(); if (w[8]) eop0--; pops0++; end
    if (p1) begin w = q1.pop_front(); if (w[8]) eop1--; pops1++; end
    @(negedge clk);
    check_out(p0 | p1);
  endtask

  task automatic clr_stats();
    pops0 = 0; pops1 = 0; bubbles = 0; errs = 0; seen_first = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete(); q1.delete(); exp_q.delete();
    eop0 = 0; eop1 = 0; stall0 = 1'b0;
    set_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clr_stats();
  endtask

  task automatic run(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("words_left", 32'(exp_q.size()), 32'd0);
    repeat (3) cycle();
  endtask

  task automatic wait_pops0(input int n);
    int k = 0;
    while (pops0 < n && k < 100) begin cycle(); k++; end
    chk("pop_wait0", 32'(pops0), 32'(n));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd0"}, 32'(rd0), 0);
    chk({tag, "_rd1"}, 32'(rd1), 0);
    chk({tag, "_dout"}, 32'(dout), 0);
    chk({tag, "_vld"}, 32'(dout_vld), 0);
    chk({tag, "_sop"}, 32'(dout_sop), 0);
    chk({tag, "_eop"}, 32'(dout_eop), 0);
    chk({tag, "_src"}, 32'(dout_src), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int anyvld;
    vectors = 0; miscompares = 0; lat_chk = 1'b0; stall0 = 1'b0;
    eop0 = 0; eop1 = 0;
    clr_stats();

    // reset state, with a pending packet on port 0
    push_pkt(0, 3, 1, 1'b0);
    set_inputs();
    repeat (2) @(negedge clk);
    check_zero("rst");

    // port 0 only, 35 bytes, contiguous with latency 1
    do_reset();
    push_pkt(0, 35, 1, 1'b0);
    lat_chk = 1'b1;
    run(200);
    lat_chk = 1'b0;
    chk("single_bubbles", 32'(bubbles), 0);
    chk("single_err", 32'(errs), 0);

    // tie after reset: port 0 first, one idle cycle, then port 1
    do_reset();
    push_pkt(0, 1532, 1, 1'b0);
    push_pkt(1, 35, 8'h80, 1'b0);
    run(3000);
    chk("tie_bubbles", 32'(bubbles), 1);
    chk("tie_err", 32'(errs), 0);

    // continuous requests alternate 0,1,0,1,0,1; last port 1 packet is single-word
    clr_stats();
    push_pkt(0, 4, 8'h10, 1'b0);
    push_pkt(1, 3, 8'h20, 1'b0);
    push_pkt(0, 5, 8'h30, 1'b0);
    push_pkt(1, 2, 8'h40, 1'b0);
    push_pkt(0, 6, 8'h50, 1'b0);
    push_pkt(1, 1, 8'h60, 1'b0);
    run(200);
    chk("alt_bubbles", 32'(bubbles), 5);
    chk("alt_err", 32'(errs), 0);

    // five-cycle valid gap mid-packet
    clr_stats();
    push_pkt(0, 12, 8'h70, 1'b0);
    wait_pops0(5);
    stall0 = 1'b1;
    repeat (5) cycle();
    stall0 = 1'b0;
    run(100);
    chk("gap_bubbles", 32'(bubbles), 5);
    chk("gap_err", 32'(errs), 0);

    // head word without sop is dropped, then a 1559-byte packet
    do_reset();
    push_pkt(0, 1559, 1, 1'b1);
    run(2000);
    chk("nosop_err", 32'(errs), 1);
    chk("nosop_bubbles", 32'(bubbles), 0);

`ifdef PKT_ARB_TIMEOUT_EN
    // stall after 4 bytes: forced eop word after 16 stalled cycles
    do_reset();
    push_pkt(0, 10, 8'h20, 1'b0);
    exp_q = exp_q[0:3];
    exp_q.push_back({1'b0, 1'b0, 1'b1, 8'h00});
    wait_pops0(4);
    stall0 = 1'b1;
    repeat (15) cycle();
    chk("to_early_vld", 32'(dout_vld), 0);
    chk("to_early_err", 32'(errs), 0);
    cycle();
    chk("to_vld", 32'(dout_vld), 1);
    chk("to_eop", 32'(dout_eop), 1);
    chk("to_dout", 32'(dout), 0);
    chk("to_err", 32'(err), 1);
    chk("to_left", 32'(exp_q.size()), 0);
`else
    // without the timeout a long stall only produces bubbles
    do_reset();
    push_pkt(0, 6, 8'h30, 1'b0);
    wait_pops0(2);
    stall0 = 1'b1;
    anyvld = 0;
    repeat (40) begin
      cycle();
      if (dout_vld) anyvld++;
    end
    chk("noto_vld", 32'(anyvld), 0);
    stall0 = 1'b0;
    run(50);
    chk("noto_bubbles", 32'(bubbles), 40);
    chk("noto_err", 32'(errs), 0);
`endif

    // reset mid-packet clears outputs immediately
    do_reset();
    push_pkt(1, 20, 8'hA0, 1'b0);
    begin
      int k = 0;
      while (pops1 < 3 && k < 50) begin cycle(); k++; end
    end
    chk("pre_rst_vld", 32'(dout_vld), 1);
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pkt_arb2.md
PKT_ARB2 -- requirements
Module: pkt_arb2

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning the data byte width.
REQ-002 The block SHALL have parameter TO_CYC, default 2047, meaning the stall-timeout limit in cycles.
REQ-003 Port clk  in  1  single clock; all logic rising-edge.
REQ-004 Port rst  in  1  asynchronous reset, active-high.
REQ-005 Ports req0/req1  in  1  upstream packet FIFO holds at least one complete packet.
REQ-006 Ports din0/din1  in  DW  upstream show-ahead head word.
REQ-007 Ports din0_vld/din1_vld, din0_sop/din1_sop, din0_eop/din1_eop  in  1 each  head-word valid, start-of-packet and end-of-packet flags.
REQ-008 Ports rd0/rd1  out  1  pop strobe; the head word is consumed on clk when rdX=1.
REQ-009 Ports dout  out  DW; dout_vld, dout_sop, dout_eop  out  1 each  merged packet stream.
REQ-010 Port dout_src  out  1  source index of the current dout word.
REQ-011 Port err  out  1  one-cycle protocol/timeout error pulse.

Function
REQ-012 The FSM SHALL have states IDLE, RD0 and RD1.
REQ-013 In IDLE with exactly one reqX=1, the FSM SHALL move to RDX on the next edge.
REQ-014 In IDLE with req0=req1=1, the FSM SHALL grant the port not equal to last_gnt.
REQ-015 last_gnt SHALL update on every grant.
REQ-016 Arbitration SHALL occur only at packet boundaries; a packet is never interleaved.
REQ-017 rdX SHALL equal (state==RDX) && dinX_vld, combinational, with no pop outside RDX.
REQ-018 A transfer (rdX=1) SHALL register dinX/sop/eop into dout/dout_sop/dout_eop with dout_vld=1 one cycle later (latency 1); otherwise dout_vld=0.
REQ-019 A dinX_vld=0 gap inside a packet SHALL produce dout_vld=0 bubbles and the FSM SHALL hold.
REQ-020 A transfer with dinX_eop=1 SHALL return the FSM to IDLE; one IDLE cycle SHALL separate packets.
REQ-021 The first transferred word of a grant lacking sop SHALL be popped and not forwarded, with err pulsed 1 cycle; the FSM SHALL stay in RDX until a sop word arrives.
REQ-022 A single-word packet (sop=eop=1) SHALL be forwarded with dout_sop=dout_eop=1.
REQ-023 reqX SHALL be ignored outside IDLE.

Reset
REQ-024 On rst=1, the block SHALL set state=IDLE, last_gnt=1 (port 0 wins first tie), and dout=0, dout_vld=0, dout_sop=0, dout_eop=0, dout_src=0, err=0, timeout counter=0.
REQ-025 rd0/rd1 SHALL be 0 during reset.
REQ-026 Reset mid-packet SHALL abandon the packet with no forced eop; upstream flushing is the upstream's responsibility.

Configuration
REQ-027 With macro PKT_ARB_TIMEOUT_EN defined, a counter SHALL count consecutive RDX cycles without a transfer and clear on each transfer.
REQ-028 With PKT_ARB_TIMEOUT_EN defined, when the counter reaches TO_CYC the FSM SHALL go to IDLE, emit one dout_vld=1 word with dout=0, dout_eop=1 and dout_sop=0, and pulse err.
REQ-029 Without PKT_ARB_TIMEOUT_EN, no counter SHALL exist and err SHALL pulse only per REQ-021.

Structure
REQ-030 Package pkt_arb_pkg SHALL hold the state enum, DW default and TO_CYC default.
REQ-031 Sub-module pkt_arb_rr SHALL implement the 2-way round-robin pick (inputs req0, req1, last_gnt; output gnt).

Verification
REQ-032 The bench SHALL cover: req0 only, 35-byte packet 1..35 -> dout 1..35 contiguous, sop on byte 1, eop on byte 35, dout_src=0, latency 1.
REQ-033 The bench SHALL cover: req0=req1=1 after reset, 1532 bytes on port 0 and 35 on port 1 -> port 0 packet fully, 1 IDLE cycle, then port 1; no interleave.
REQ-034 The bench SHALL cover: both ports continuously requesting 3 packets each -> grants alternate 0,1,0,1,0,1.
REQ-035 The bench SHALL cover: din0_vld low for 5 cycles mid-packet -> 5 dout_vld=0 bubbles, data order intact.
REQ-036 The bench SHALL cover: head word without sop followed by a valid 1559-byte packet -> bad word dropped, err=1 for 1 cycle, 1559 bytes forwarded.
REQ-037 The bench SHALL cover, with PKT_ARB_TIMEOUT_EN and TO_CYC=16: din0_vld stuck low mid-packet -> after 16 stalled cycles, forced dout_eop word with dout=0 and err pulse; then rst asserted mid-packet -> all outputs 0 immediately.
